// File: rtl/fetcher.sv
// Instruction fetch stage: fetches one instruction per core FETCH through a
// valid/ready handshake, with a single-entry line buffer and a hung-memory timeout.
module fetcher #(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
  parameter int unsigned TIMEOUT_CYCLES        = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic                             fetch_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PROGRAM_MEM_DATA_BITS-1:0] RET_INSTR = PROGRAM_MEM_DATA_BITS'(16'hF000);
  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_FETCHING = 3'b001,
    S_FETCHED  = 3'b010
  } state_t;

  state_t                             state, state_d;
  logic                               valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   instr_d;
  logic                               err_d;
  logic [CNT_W-1:0]                   cnt, cnt_d;
  logic                               buf_valid, buf_valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   buf_tag, buf_tag_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   buf_data, buf_data_d;

  assign fetcher_state = state;

  // State and all output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      fetch_error      <= 1'b0;
      cnt              <= '0;
      buf_valid        <= 1'b0;
      buf_tag          <= '0;
      buf_data         <= '0;
    end else begin
      state            <= state_d;
      mem_read_valid   <= valid_d;
      mem_read_address <= addr_d;
      instruction      <= instr_d;
      fetch_error      <= err_d;
      cnt              <= cnt_d;
      buf_valid        <= buf_valid_d;
      buf_tag          <= buf_tag_d;
      buf_data         <= buf_data_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    valid_d     = mem_read_valid;
    addr_d      = mem_read_address;
    instr_d     = instruction;
    err_d       = fetch_error;
    cnt_d       = cnt;
    buf_valid_d = buf_valid;
    buf_tag_d   = buf_tag;
    buf_data_d  = buf_data;

    unique case (state)
      S_IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (buf_valid && (buf_tag == current_pc)) begin
            instr_d = buf_data;
            state_d = S_FETCHED;
          end else begin
            valid_d = 1'b1;
            addr_d  = current_pc;
            cnt_d   = '0;
            state_d = S_FETCHING;
          end
        end
      end
      S_FETCHING: begin
        // Ready beats the timeout when both land on the same edge
        if (mem_read_ready) begin
          instr_d     = mem_read_data;
          buf_valid_d = 1'b1;
          buf_tag_d   = mem_read_address;
          buf_data_d  = mem_read_data;
          valid_d     = 1'b0;
          state_d     = S_FETCHED;
        end else if (cnt == CNT_LAST) begin
          valid_d = 1'b0;
          instr_d = RET_INSTR;
          err_d   = 1'b1;
          state_d = S_FETCHED;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_FETCHED: begin
        if (core_state == CORE_DECODE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides a same-edge fill
    if (flush) buf_valid_d = 1'b0;
  end

endmodule

// File: tb/tb_fetcher.sv
// Directed self-checking bench for fetcher (timeout shortened to 4 cycles).
module tb_fetcher;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  core_state = 3'b000;
  logic [7:0]  current_pc = 8'h00;
  logic        flush = 1'b0;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'h0000;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic        fetch_error;

  int n_checks = 0;
  int n_errors = 0;

  fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_state(core_state),
    .current_pc(current_pc),
    .flush(flush),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state),
    .instruction(instruction),
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand FETCHED back to IDLE via DECODE
  task automatic to_idle();
    core_state = 3'b010;
    tick();
    core_state = 3'b000;
  endtask

  initial begin
    #3;
    check("rst_state", 32'(fetcher_state), 32'h0);
    check("rst_valid", 32'(mem_read_valid), 32'h0);
    check("rst_addr", 32'(mem_read_address), 32'h0);
    check("rst_instr", 32'(instruction), 32'h0);
    check("rst_err", 32'(fetch_error), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Miss at 0x05, ready three cycles after the request edge
    current_pc = 8'h05;
    core_state = 3'b001;
    tick();
    core_state = 3'b000;
    check("miss_state", 32'(fetcher_state), 32'h1);
    check("miss_valid", 32'(mem_read_valid), 32'h1);
    check("miss_addr", 32'(mem_read_address), 32'h05);
    current_pc = 8'h77;
    tick();
    check("miss_hold_valid", 32'(mem_read_valid), 32'h1);
    check("miss_hold_addr", 32'(mem_read_address), 32'h05);
    tick();
    check("miss_hold_addr2", 32'(mem_read_address), 32'h05);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h3123;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0000;
    check("miss_done_state", 32'(fetcher_state), 32'h2);
    check("miss_done_instr", 32'(instruction), 32'h3123);
    check("miss_done_valid", 32'(mem_read_valid), 32'h0);
    tick();
    check("fetched_hold", 32'(fetcher_state), 32'h2);
    to_idle();
    check("decode_idle", 32'(fetcher_state), 32'h0);
    check("decode_instr_held", 32'(instruction), 32'h3123);

    // Hit at 0x05: one cycle, no request
    current_pc = 8'h05;
    core_state = 3'b001;
    tick();
    core_state = 3'b000;
    check("hit_state", 32'(fetcher_state), 32'h2);
    check("hit_valid", 32'(mem_read_valid), 32'h0);
    check("hit_instr", 32'(instruction), 32'h3123);
    to_idle();

    // Flush pulse forces a miss
    flush = 1'b1;
    tick();
    flush = 1'b0;
    core_state = 3'b001;
    tick();
    core_state = 3'b000;
    check("flush_miss_state", 32'(fetcher_state), 32'h1);
    check("flush_miss_valid", 32'(mem_read_valid), 32'h1);
    // Flush on the same edge as ready: data delivered, buffer left invalid
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h4ABC;
    flush = 1'b1;
    tick();
    mem_read_ready = 1'b0;
    flush = 1'b0;
    check("flush_fill_instr", 32'(instruction), 32'h4ABC);
    check("flush_fill_state", 32'(fetcher_state), 32'h2);
    to_idle();
    core_state = 3'b001;
    tick();
    core_state = 3'b000;
    check("flush_fill_miss", 32'(fetcher_state), 32'h1);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h1111;
    tick();
    mem_read_ready = 1'b0;
    check("refill_instr", 32'(instruction), 32'h1111);
    to_idle();

    // Timeout at 0x20: four edges in FETCHING with no ready
    current_pc = 8'h20;
    core_state = 3'b001;
    tick();
    core_state = 3'b000;
    check("to_start", 32'(fetcher_state), 32'h1);
    for (int i = 0; i < 3; i++) tick();
    check("to_still_fetching", 32'(fetcher_state), 32'h1);
    check("to_still_valid", 32'(mem_read_valid), 32'h1);
    check("to_no_err_yet", 32'(fetch_error), 32'h0);
    tick();
    check("to_state", 32'(fetcher_state), 32'h2);
    check("to_instr", 32'(instruction), 32'hF000);
    check("to_err", 32'(fetch_error), 32'h1);
    check("to_valid", 32'(mem_read_valid), 32'h0);
    to_idle();
    // Good hit keeps the sticky error
    current_pc = 8'h05;
    core_state = 3'b001;
    tick();
    core_state = 3'b000;
    check("sticky_hit_instr", 32'(instruction), 32'h1111);
    check("sticky_hit_err", 32'(fetch_error), 32'h1);
    to_idle();
    // Timed-out address was not buffered
    current_pc = 8'h20;
    core_state = 3'b001;
    tick();
    core_state = 3'b000;
    check("to_not_buffered", 32'(fetcher_state), 32'h1);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h5A5A;
    tick();
    mem_read_ready = 1'b0;
    check("sticky_miss_instr", 32'(instruction), 32'h5A5A);
    check("sticky_miss_err", 32'(fetch_error), 32'h1);
    to_idle();

    // Async reset mid-FETCHING, between edges
    current_pc = 8'h30;
    core_state = 3'b001;
    tick();
    core_state = 3'b000;
    check("pre_rst_valid", 32'(mem_read_valid), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    check("arst_state", 32'(fetcher_state), 32'h0);
    check("arst_valid", 32'(mem_read_valid), 32'h0);
    check("arst_addr", 32'(mem_read_address), 32'h0);
    check("arst_instr", 32'(instruction), 32'h0);
    check("arst_err", 32'(fetch_error), 32'h0);
    #1;
    reset = 1'b1;
    tick();
    check("post_rst_idle", 32'(fetcher_state), 32'h0);

    // 0x05 misses after reset; ready lands exactly on the timeout edge
    current_pc = 8'h05;
    core_state = 3'b001;
    tick();
    core_state = 3'b000;
    check("post_rst_miss", 32'(fetcher_state), 32'h1);
    for (int i = 0; i < 3; i++) tick();
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h2468;
    tick();
    mem_read_ready = 1'b0;
    check("edge_ready_state", 32'(fetcher_state), 32'h2);
    check("edge_ready_instr", 32'(instruction), 32'h2468);
    check("edge_ready_err", 32'(fetch_error), 32'h0);
    to_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction fetch stage of each miniGPU core, directly upstream of the decoder. On the core's FETCH state it reads the 16-bit instruction at the current PC from program memory through a valid/ready handshake. It holds the instruction stable for the decoder until the core enters DECODE. A single-entry line buffer short-circuits repeated fetches of the same PC. A timeout converts a hung memory into a forced RET plus a sticky error flag.

## Interface
- PROGRAM_MEM_ADDR_BITS, 8, program memory address / PC width
- PROGRAM_MEM_DATA_BITS, 16, instruction width
- TIMEOUT_CYCLES, 255, maximum cycles spent in FETCHING before abort (≥2)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- core_state  in  3  core FSM state: IDLE=000, FETCH=001, DECODE=010, others ignored
- current_pc  in  PROGRAM_MEM_ADDR_BITS  PC to fetch, sampled in IDLE when core_state=FETCH
- flush  in  1  invalidate line buffer (program memory reloaded)
- mem_read_valid  out  1  read request to program memory
- mem_read_address  out  PROGRAM_MEM_ADDR_BITS  request address
- mem_read_ready  in  1  memory has returned data this cycle
- mem_read_data  in  PROGRAM_MEM_DATA_BITS  returned instruction
- fetcher_state  out  3  IDLE=000, FETCHING=001, FETCHED=010
- instruction  out  PROGRAM_MEM_DATA_BITS  instruction for decoder, valid in FETCHED
- fetch_error  out  1  sticky: a fetch timed out since reset

## Operation
- Reset (reset=0, any time, including mid-handshake): fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, fetch_error=0, timeout counter=0, line buffer invalid (tag=0, data=0). Outstanding request is abandoned.
- IDLE, core_state≠FETCH: hold all outputs.
- IDLE, core_state=FETCH, buffer valid and tag==current_pc (hit): instruction<=buffer data, go FETCHED. No memory request.
- IDLE, core_state=FETCH, miss: mem_read_valid<=1, mem_read_address<=current_pc, counter<=0, go FETCHING.
- FETCHING: valid and address held constant until accepted.
  - mem_read_ready=1: instruction<=mem_read_data, buffer<={valid, current address, data}, mem_read_valid<=0, go FETCHED.
  - Otherwise counter+1. When counter reaches TIMEOUT_CYCLES-1 with no ready: mem_read_valid<=0, instruction<=16'hF000 (RET), fetch_error<=1, go FETCHED. Buffer not updated.
  - Ready on the timeout edge: ready wins, no error.
- FETCHED: hold instruction; when core_state=DECODE go IDLE (instruction still held).
- flush=1: buffer invalid next edge in any state. Flush and a buffer fill on the same edge: flush wins (buffer ends invalid, instruction still delivered). Flush never aborts an in-flight request.
- core_state changes while FETCHING are ignored; the request always completes or times out.

## Timing
- Miss: core_state=FETCH sampled at edge t → mem_read_valid=1 after t. mem_read_ready sampled high at edge k → FETCHED with instruction after k, mem_read_valid=0 after k. Minimum miss latency is 2 cycles (ready at t+1).
- Hit: FETCH sampled at t → FETCHED with instruction after t (1 cycle).
- Timeout: FETCHED after TIMEOUT_CYCLES edges in FETCHING.
- All outputs registered. No combinational path from inputs to outputs.

## Test plan
- Reset then miss: current_pc=0x05, FETCH, memory returns 16'h3123 with ready 3 cycles later → mem_read_address=0x05 held while valid, instruction=16'h3123, fetcher_state=010, valid drops the following cycle.
- Hit: repeat FETCH at pc=0x05 after DECODE → FETCHED one cycle later, mem_read_valid never asserted, instruction=16'h3123.
- Flush: flush pulse, FETCH at pc=0x05 → memory request issued (miss). Flush on the same edge as ready → next fetch of 0x05 also misses.
- Timeout: TIMEOUT_CYCLES=4, ready never asserted → FETCHED after 4 cycles, instruction=16'hF000, fetch_error=1, stays 1 after further good fetches.
- Ready on the timeout edge → normal data captured, fetch_error=0.
- Async reset asserted mid-FETCHING, between edges → outputs zero immediately. After release, a FETCH at pc=0x05 misses (buffer invalid).
